sr_latch_driver: RTL and testbench
==================================

Name: sr_latch_driver

Overview:
Synchronous controller that drives the set/reset inputs of an SR (NOR) latch (s, r; q, qb feedback) from a valid/ready write request.
- Produces timed s/r pulses and never asserts s and r together.
- Confirms the latch reached the requested state via q/qb feedback; reports done, timeout or invalid-state errors.
- Sits between control logic and any SR storage element, as the driving end of the latch's s/r interface.

Parameters:
PULSE_CYCLES, 2, clock cycles s or r is held high per write (>=1)
TIMEOUT_CYCLES, 8, WAIT-state sample edges before an error is declared (>=1)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  write request valid
req_ready  output  1  high only in IDLE; a request is accepted on a clk edge with req_valid&&req_ready
req_val  input  1  requested latch value (1=set, 0=reset); captured at accept
s  output  1  latch set drive, registered
r  output  1  latch reset drive, registered
q_fb  input  1  latch q feedback (treated as asynchronous; see Behaviour)
qb_fb  input  1  latch qb feedback
busy  output  1  high in PULSE and WAIT
done  output  1  one-cycle pulse: latch confirmed at requested value
err  output  1  one-cycle pulse: write failed
err_code  output  2  00 none, 01 timeout with wrong value, 10 q_fb==qb_fb at timeout; valid with err, held until next accept

Behaviour:
- Reset (async, any state): s=0, r=0, state=IDLE, req_ready=1, busy=0, done=0, err=0, err_code=00, counter=0. Takes effect immediately, mid-pulse included, so the latch holds its value.
- States: IDLE, PULSE, WAIT. Let E0 be the accept edge and Ek the k-th edge after it.
- IDLE:
  - s=r=0, req_ready=1.
  - On accept: capture req_val as target and clear err_code to 00.
  - Skip path: if q_fb==target and qb_fb==~target at E0, stay in IDLE, issue no pulse, and assert done for the cycle after E0.
  - Otherwise go to PULSE with counter=PULSE_CYCLES-1.
- PULSE:
  - s=target, r=~target, both registered: high from E0 through E(PULSE_CYCLES).
  - The counter decrements each edge; at 0, drop s/r to 0 and go to WAIT with counter=TIMEOUT_CYCLES-1.
  - s and r are never 1 in the same cycle, including on any transition.
- WAIT:
  - s=r=0; sample feedback each edge.
  - Match (q_fb==target and qb_fb==~target): done=1 next cycle, return to IDLE.
  - q_fb==qb_fb is a transient, not a failure.
  - If no match by the TIMEOUT_CYCLES-th WAIT edge, assert err next cycle, return to IDLE, and set err_code=10 if q_fb==qb_fb at that edge, else 01.
- done and err are mutually exclusive, one cycle each. req_ready rises in the same cycle done/err is high, so a back-to-back accept is possible on the following edge.
- req_valid while busy is ignored and no request is queued; req_val changes after accept have no effect.
- q_fb and qb_fb pass through a 2-flop synchronizer before all comparisons, including the skip check. This adds 2 cycles to the match/skip decision; all cycle counts above are counted from the synchronized values.
- Counter width is clog2(max(PULSE_CYCLES, TIMEOUT_CYCLES)); minimum 1 bit.

Decomposition:
- Shared package sr_drv_pkg holds:
  - state enum {IDLE, PULSE, WAIT};
  - err_code constants ERR_NONE=2'b00, ERR_TIMEOUT=2'b01, ERR_INVALID=2'b10.
- One sub-module, sr_drv_counter: loadable down-counter with zero flag, shared by PULSE and WAIT, same clk/rst.
- The synchronizer is inline.

Test Plan:
Defaults PULSE_CYCLES=2, TIMEOUT_CYCLES=8; the bench uses a behavioural NOR latch with a 1-cycle delay.
1. Set: latch q=0/qb=1, req_val=1 accepted at E0 -> s=1 from E0 to E2, r=0 throughout, done one cycle within WAIT, err=0, busy low after done.
2. Reset: latch q=1, req_val=0 -> r=1 for 2 cycles, s=0 throughout, done pulse, final q_fb=0/qb_fb=1.
3. Already held: latch q=1 (synchronized), req_val=1 -> no s/r pulse, done the cycle after E0, busy stays 0.
4. Stuck latch: q_fb=0/qb_fb=1 forced, req_val=1 -> s pulse 2 cycles, err the cycle after E10, err_code=01, no done.
5. Invalid feedback: q_fb=qb_fb=1 forced during WAIT -> err after E10, err_code=10.
6. Reset mid-pulse: rst=1 while s=1 -> s=0 with no clock edge, done/err never assert; after release req_ready=1 and a new write completes normally. Also drive req_valid=1 while busy -> ignored, exactly one done.

Source files
------------

// File: rtl/sr_latch_driver_pkg.sv
// Shared types and constants for the SR latch driver and its counter.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_INVALID = 2'b10;

  // Width of a down-counter that must hold values up to max(a, b) - 1; never
  // narrower than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Request and latch-drive signals of the SR latch driver.
// slave is the driver itself; master is the requester plus the latch feedback.
interface sr_latch_driver_if;

  logic       req_valid;
  logic       req_ready;
  logic       req_val;
  logic       s;
  logic       r;
  logic       q_fb;
  logic       qb_fb;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;

  modport master (
    output req_valid, req_val, q_fb, qb_fb,
    input  req_ready, s, r, busy, done, err, err_code
  );

  modport slave (
    input  req_valid, req_val, q_fb, qb_fb,
    output req_ready, s, r, busy, done, err, err_code
  );

endinterface

// File: rtl/sr_latch_driver_counter.sv
// Loadable down-counter with zero flag; times both the drive pulse and the
// feedback wait window.
module sr_drv_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: load wins over decrement; decrement saturates at zero.
  always_comb begin
    // NOTE: assign a default first so every path drives count_d and no latch is inferred.
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Drives the s/r inputs of an SR (NOR) latch from a valid/ready write request,
// then confirms the new state through synchronized q/qb feedback.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 8
) (
  input logic              clk,
  input logic              rst,
  sr_latch_driver_if.slave bus
);

  localparam int             CW           = cnt_width(PULSE_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  PULSE_LOAD   = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0]  TIMEOUT_LOAD = CW'(TIMEOUT_CYCLES - 1);

  state_t     state_q,    state_d;
  logic       target_q,   target_d;
  logic       s_q,        s_d;
  logic       r_q,        r_d;
  logic       done_q,     done_d;
  logic       err_q,      err_d;
  logic [1:0] err_code_q, err_code_d;

  logic       q_meta_q,   q_meta_d;
  logic       q_sync_q,   q_sync_d;
  logic       qb_meta_q,  qb_meta_d;
  logic       qb_sync_q,  qb_sync_d;

  logic          cnt_load;
  logic [CW-1:0] cnt_load_val;
  logic          cnt_dec;
  logic [CW-1:0] cnt_count;
  logic          cnt_zero;

  logic accept;
  logic match;
  logic skip;

  // Shared timer for the drive pulse and the feedback wait window.
  sr_drv_counter #(
    .WIDTH (CW)
  ) u_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .count    (cnt_count),
    .zero     (cnt_zero)
  );

  // Two-stage synchronizer inputs for the asynchronous latch feedback.
  always_comb begin
    q_meta_d  = bus.q_fb;
    q_sync_d  = q_meta_q;
    qb_meta_d = bus.qb_fb;
    qb_sync_d = qb_meta_q;
  end

  // Synchronizer flops; all decisions below use only the *_sync_q outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_meta_q  <= 1'b0;
      q_sync_q  <= 1'b0;
      qb_meta_q <= 1'b0;
      qb_sync_q <= 1'b0;
    end else begin
      q_meta_q  <= q_meta_d;
      q_sync_q  <= q_sync_d;
      qb_meta_q <= qb_meta_d;
      qb_sync_q <= qb_sync_d;
    end
  end

  assign accept = (state_q == IDLE) && bus.req_valid;
  // Skip compares against the incoming value since target is not yet captured.
  assign skip   = (q_sync_q == bus.req_val) && (qb_sync_q == ~bus.req_val);
  assign match  = (q_sync_q == target_q) && (qb_sync_q == ~target_q);

  // Next-state and output decode: IDLE accepts, PULSE drives, WAIT confirms.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    s_d          = 1'b0;
    r_d          = 1'b0;
    done_d       = 1'b0;
    err_d        = 1'b0;
    err_code_d   = err_code_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          target_d   = bus.req_val;
          err_code_d = ERR_NONE;
          if (skip) begin
            // Latch already holds the value: confirm without pulsing.
            done_d = 1'b1;
          end else begin
            state_d      = PULSE;
            s_d          = bus.req_val;
            r_d          = ~bus.req_val;
            cnt_load     = 1'b1;
            cnt_load_val = PULSE_LOAD;
          end
        end
      end

      PULSE: begin
        if (cnt_zero) begin
          // Drive released here (s_d/r_d default low) before feedback is judged.
          state_d      = WAIT;
          cnt_load     = 1'b1;
          cnt_load_val = TIMEOUT_LOAD;
        end else begin
          s_d     = target_q;
          r_d     = ~target_q;
          cnt_dec = 1'b1;
        end
      end

      WAIT: begin
        if (match) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (cnt_zero) begin
          // q==qb on the final sample means the latch never settled validly.
          state_d    = IDLE;
          err_d      = 1'b1;
          err_code_d = (q_sync_q == qb_sync_q) ? ERR_INVALID : ERR_TIMEOUT;
        end else begin
          cnt_dec = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state and registered outputs; reset drops s/r immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      target_q   <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      s_q        <= s_d;
      r_q        <= r_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.s         = s_q;
  assign bus.r         = r_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with a behavioural NOR latch model
// (one clock of delay) whose feedback can be overridden.
module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic rst;

  logic lq = 1'b0;
  logic force_en;
  logic fq;
  logic fqb;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt;

  sr_latch_driver_if bus ();

  sr_latch_driver #(
    .PULSE_CYCLES   (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Latch model: state follows s/r one edge later; holds otherwise.
  always @(posedge clk) begin
    if (bus.s && !bus.r)      lq <= 1'b1;
    else if (bus.r && !bus.s) lq <= 1'b0;
  end

  assign bus.q_fb  = force_en ? fq  : lq;
  assign bus.qb_fb = force_en ? fqb : ~lq;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle to the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_val   = 1'b0;
    force_en      = 1'b0;
    fq            = 1'b0;
    fqb           = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_ready", bus.req_ready, 1);
    check("rst_busy",  bus.busy, 0);
    check("rst_s",     bus.s, 0);
    check("rst_r",     bus.r, 0);
    check("rst_done",  bus.done, 0);
    check("rst_err",   bus.err, 0);
    check("rst_code",  bus.err_code, 0);
    rst = 1'b0;
    repeat (3) tick();

    // 1. Set from q=0
    bus.req_valid = 1'b1;
    bus.req_val   = 1'b1;
    check("t1_ready_pre", bus.req_ready, 1);
    tick(); // E0
    bus.req_valid = 1'b0;
    check("t1_e0_s",     bus.s, 1);
    check("t1_e0_r",     bus.r, 0);
    check("t1_e0_busy",  bus.busy, 1);
    check("t1_e0_ready", bus.req_ready, 0);
    tick(); // E1
    check("t1_e1_s", bus.s, 1);
    check("t1_e1_r", bus.r, 0);
    tick(); // E2
    check("t1_e2_s",    bus.s, 0);
    check("t1_e2_busy", bus.busy, 1);
    tick(); // E3
    check("t1_e3_done", bus.done, 0);
    tick(); // E4
    check("t1_e4_done",  bus.done, 1);
    check("t1_e4_err",   bus.err, 0);
    check("t1_e4_busy",  bus.busy, 0);
    check("t1_e4_ready", bus.req_ready, 1);
    tick(); // E5
    check("t1_e5_done", bus.done, 0);

    // 3. Already held at 1: skip path
    bus.req_valid = 1'b1;
    bus.req_val   = 1'b1;
    tick(); // E0
    bus.req_valid = 1'b0;
    check("t3_done", bus.done, 1);
    check("t3_s",    bus.s, 0);
    check("t3_r",    bus.r, 0);
    check("t3_busy", bus.busy, 0);
    tick();
    check("t3_done_end", bus.done, 0);
    check("t3_s_end",    bus.s, 0);

    // 2. Reset from q=1
    bus.req_valid = 1'b1;
    bus.req_val   = 1'b0;
    tick(); // E0
    bus.req_valid = 1'b0;
    check("t2_e0_r", bus.r, 1);
    check("t2_e0_s", bus.s, 0);
    tick(); // E1
    check("t2_e1_r", bus.r, 1);
    check("t2_e1_s", bus.s, 0);
    tick(); // E2
    check("t2_e2_r", bus.r, 0);
    tick(); // E3
    check("t2_e3_done", bus.done, 0);
    tick(); // E4
    check("t2_e4_done", bus.done, 1);
    check("t2_q_fb",    bus.q_fb, 0);
    check("t2_qb_fb",   bus.qb_fb, 1);
    tick();
    check("t2_e5_done", bus.done, 0);

    // 4. Stuck latch: feedback pinned at q=0/qb=1
    force_en = 1'b1;
    fq       = 1'b0;
    fqb      = 1'b1;
    repeat (3) tick();
    bus.req_valid = 1'b1;
    bus.req_val   = 1'b1;
    tick(); // E0
    bus.req_valid = 1'b0;
    check("t4_e0_s", bus.s, 1);
    tick(); // E1
    check("t4_e1_s", bus.s, 1);
    tick(); // E2
    check("t4_e2_s", bus.s, 0);
    for (int k = 3; k <= 9; k++) begin
      tick();
      check($sformatf("t4_e%0d_done", k), bus.done, 0);
      check($sformatf("t4_e%0d_err", k),  bus.err, 0);
    end
    tick(); // E10
    check("t4_e10_err",   bus.err, 1);
    check("t4_e10_code",  bus.err_code, 2'b01);
    check("t4_e10_done",  bus.done, 0);
    check("t4_e10_ready", bus.req_ready, 1);
    tick();
    check("t4_e11_err",  bus.err, 0);
    check("t4_e11_code", bus.err_code, 2'b01);

    // 5. Invalid feedback q=qb=1 during WAIT
    bus.req_valid = 1'b1;
    bus.req_val   = 1'b1;
    tick(); // E0
    bus.req_valid = 1'b0;
    check("t5_e0_code", bus.err_code, 2'b00);
    tick(); // E1
    tick(); // E2
    fq  = 1'b1;
    fqb = 1'b1;
    for (int k = 3; k <= 9; k++) begin
      tick();
      check($sformatf("t5_e%0d_err", k), bus.err, 0);
    end
    tick(); // E10
    check("t5_e10_err",  bus.err, 1);
    check("t5_e10_code", bus.err_code, 2'b10);
    check("t5_e10_done", bus.done, 0);
    tick();

    // 6. Reset mid-pulse, then a write with req_valid held during busy
    force_en = 1'b0; // latch model holds 1 after the pulses above
    repeat (3) tick();
    bus.req_valid = 1'b1;
    bus.req_val   = 1'b0;
    tick(); // E0
    bus.req_valid = 1'b0;
    check("t6_pulse_r", bus.r, 1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_r",     bus.r, 0);
    check("t6_async_s",     bus.s, 0);
    check("t6_async_busy",  bus.busy, 0);
    check("t6_async_ready", bus.req_ready, 1);
    check("t6_async_done",  bus.done, 0);
    check("t6_async_err",   bus.err, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("t6_rst%0d_done", k), bus.done, 0);
      check($sformatf("t6_rst%0d_err", k),  bus.err, 0);
    end
    rst = 1'b0;
    check("t6_latch_held", bus.q_fb, 1);
    repeat (3) tick();
    check("t6_rel_ready", bus.req_ready, 1);

    done_cnt      = 0;
    bus.req_valid = 1'b1;
    bus.req_val   = 1'b0;
    tick(); // E0
    bus.req_val   = 1'b1; // must have no effect on the accepted write
    check("t6_w_r", bus.r, 1);
    check("t6_w_s", bus.s, 0);
    if (bus.done) done_cnt++;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (bus.done) done_cnt++;
    end
    bus.req_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.done) done_cnt++;
    end
    check("t6_done_count", 8'(done_cnt), 1);
    check("t6_final_q",    bus.q_fb, 0);
    check("t6_final_qb",   bus.qb_fb, 1);
    check("t6_final_err",  bus.err, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
